// File: rtl/axi_axis_mux_writer_pkg.sv
// Shared encodings and helpers for the AXI4-Lite to multi-channel AXI-Stream writer.
package axi_axis_mux_writer_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_axis_mux_writer_fifo.sv
// Per-channel synchronous FIFO with an AXI-Stream read side; push is dropped when full.
module axis_sync_fifo
   import axi_axis_mux_writer_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned PW    = clog2(DEPTH),
   localparam int unsigned CW    = clog2(DEPTH + 1)
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_tvalid,
   input  logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Fullness uses the pre-pop count, so a simultaneous pop never frees a slot early.
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_tvalid = (r_count != '0);
   assign o_tdata  = r_mem[r_rptr];
   assign o_count  = r_count;
   assign w_push   = i_push && !o_full;
   assign w_pop    = o_tvalid && i_tready;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/axi_axis_mux_writer.sv
// AXI4-Lite slave that routes each write into one of CHANNELS stream FIFOs; reads return fill counts.
module axi_axis_mux_writer
   import axi_axis_mux_writer_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned CHANNELS       = 2,
   parameter int unsigned FIFO_DEPTH     = 16
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                               s_axi_awvalid,
   output logic                               s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic                               s_axi_wvalid,
   output logic                               s_axi_wready,
   output logic [1:0]                         s_axi_bresp,
   output logic                               s_axi_bvalid,
   input  logic                               s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                               s_axi_arvalid,
   output logic                               s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                         s_axi_rresp,
   output logic                               s_axi_rvalid,
   input  logic                               s_axi_rready,
   output logic [CHANNELS*AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [CHANNELS-1:0]                m_axis_tvalid,
   input  logic [CHANNELS-1:0]                m_axis_tready
);

   localparam int unsigned CH_BITS = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
   localparam int unsigned CW      = clog2(FIFO_DEPTH + 1);

   logic                      r_rst_done;
   logic                      r_aw_held;
   logic [CH_BITS-1:0]        r_aw_ch;
   logic                      r_w_held;
   logic [AXI_DATA_WIDTH-1:0] r_wdata;
   logic                      r_bvalid;
   logic [1:0]                r_bresp;
   logic                      r_rvalid;
   logic [1:0]                r_rresp;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;

   logic [CH_BITS-1:0]        w_ar_ch;
   logic                      w_ar_in_range;
   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_ar_hs;
   logic                      w_attempt;
   logic                      w_sel_full;
   logic [CW-1:0]             w_ar_count;
   logic [CHANNELS-1:0]       w_full;
   logic [CW-1:0]             w_count [CHANNELS];
   logic                      w_unused;

   // Only the channel-select bits of the addresses matter.
   assign w_unused      = ^{s_axi_awaddr, s_axi_araddr};
   assign w_ar_ch       = s_axi_araddr[2 +: CH_BITS];
   assign w_ar_in_range = (32'(w_ar_ch) < CHANNELS);

   assign s_axi_awready = r_rst_done && !r_aw_held && !r_bvalid;
   assign s_axi_wready  = r_rst_done && !r_w_held && !r_bvalid;
   assign s_axi_arready = r_rst_done && !r_rvalid;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;

   assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
   assign w_w_hs    = s_axi_wvalid && s_axi_wready;
   assign w_ar_hs   = s_axi_arvalid && s_axi_arready;
   assign w_attempt = r_aw_held && r_w_held;

   // An out-of-range channel reads as permanently full, which yields SLVERR.
   always_comb begin
      w_sel_full = 1'b1;
      w_ar_count = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (r_aw_ch == CH_BITS'(k)) w_sel_full = w_full[k];
         if (w_ar_ch == CH_BITS'(k)) w_ar_count = w_count[k];
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rst_done <= 1'b0;
         r_aw_held  <= 1'b0;
         r_aw_ch    <= '0;
         r_w_held   <= 1'b0;
         r_wdata    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= '0;
      end else begin
         r_rst_done <= 1'b1;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_ch   <= s_axi_awaddr[2 +: CH_BITS];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi_wdata;
         end
         if (w_attempt) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_sel_full ? RESP_SLVERR : RESP_OKAY;
         end else if (r_bvalid && s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rvalid <= 1'b0;
         r_rresp  <= '0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
         r_rdata  <= w_ar_in_range ? AXI_DATA_WIDTH'(w_ar_count) : '0;
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      axis_sync_fifo #(
         .WIDTH (AXI_DATA_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .aclk     (aclk),
         .aresetn  (aresetn),
         .i_push   (w_attempt && (r_aw_ch == CH_BITS'(k))),
         .i_data   (r_wdata),
         .o_full   (w_full[k]),
         .o_tvalid (m_axis_tvalid[k]),
         .i_tready (m_axis_tready[k]),
         .o_tdata  (m_axis_tdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]),
         .o_count  (w_count[k])
      );
   end

endmodule

// File: tb/tb_axi_axis_mux_writer.sv
// Randomized bench with a queue-based reference model of the AXI-Lite to stream mux.
module tb_axi_axis_mux_writer;

   localparam int unsigned DW    = 32;
   localparam int unsigned CH    = 3;
   localparam int unsigned DEPTH = 16;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [31:0]     s_axi_awaddr;
   logic            s_axi_awvalid;
   logic            s_axi_awready;
   logic [DW-1:0]   s_axi_wdata;
   logic            s_axi_wvalid;
   logic            s_axi_wready;
   logic [1:0]      s_axi_bresp;
   logic            s_axi_bvalid;
   logic            s_axi_bready;
   logic [31:0]     s_axi_araddr;
   logic            s_axi_arvalid;
   logic            s_axi_arready;
   logic [DW-1:0]   s_axi_rdata;
   logic [1:0]      s_axi_rresp;
   logic            s_axi_rvalid;
   logic            s_axi_rready;
   logic [CH*DW-1:0] m_axis_tdata;
   logic [CH-1:0]   m_axis_tvalid;
   logic [CH-1:0]   m_axis_tready;
   logic [CH-1:0]   tr_man;
   logic [CH-1:0]   tr_rnd;
   logic            rnd_mode;
   logic            chk_en;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;
   assign m_axis_tready = rnd_mode ? tr_rnd : tr_man;

   axi_axis_mux_writer #(
      .AXI_DATA_WIDTH (DW),
      .AXI_ADDR_WIDTH (32),
      .CHANNELS       (CH),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: one queue per channel plus the handshake bookkeeping.
   logic [31:0] mq [CH][$];
   bit          m_rst_done, m_aw_held, m_w_held, m_bvalid, m_rvalid;
   int unsigned m_aw_ch;
   logic [31:0] m_wdata, m_rdata;
   logic [1:0]  m_bresp, m_rresp;

   always @(posedge aclk) begin : model
      bit aw_rdy, w_rdy, ar_rdy, push_ok, attempt;
      int unsigned ch;
      if (!aresetn) begin
         for (int k = 0; k < CH; k++) mq[k].delete();
         m_rst_done = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
      end else begin
         aw_rdy  = m_rst_done && !m_aw_held && !m_bvalid;
         w_rdy   = m_rst_done && !m_w_held && !m_bvalid;
         ar_rdy  = m_rst_done && !m_rvalid;
         attempt = m_aw_held && m_w_held;
         push_ok = 0;
         if (s_axi_arvalid && ar_rdy) begin
            ch       = (s_axi_araddr >> 2) % 4;
            m_rvalid = 1;
            m_rdata  = (ch < CH) ? 32'(mq[ch].size()) : 32'd0;
            m_rresp  = (ch < CH) ? 2'b00 : 2'b10;
         end else if (m_rvalid && s_axi_rready) begin
            m_rvalid = 0;
         end
         if (attempt) push_ok = (m_aw_ch < CH) && (mq[m_aw_ch].size() < DEPTH);
         for (int k = 0; k < CH; k++)
            if (mq[k].size() > 0 && m_axis_tready[k]) void'(mq[k].pop_front());
         if (push_ok) mq[m_aw_ch].push_back(m_wdata);
         if (attempt) begin
            m_aw_held = 0; m_w_held = 0; m_bvalid = 1;
            m_bresp   = push_ok ? 2'b00 : 2'b10;
         end else if (m_bvalid && s_axi_bready) begin
            m_bvalid = 0;
         end
         if (s_axi_awvalid && aw_rdy) begin m_aw_held = 1; m_aw_ch = (s_axi_awaddr >> 2) % 4; end
         if (s_axi_wvalid && w_rdy) begin m_w_held = 1; m_wdata = s_axi_wdata; end
         m_rst_done = 1;
      end
   end

   always @(negedge aclk) begin
      if (chk_en) begin
         check("awready", s_axi_awready, m_rst_done && !m_aw_held && !m_bvalid);
         check("wready", s_axi_wready, m_rst_done && !m_w_held && !m_bvalid);
         check("arready", s_axi_arready, m_rst_done && !m_rvalid);
         check("bvalid", s_axi_bvalid, m_bvalid);
         if (m_bvalid) check("bresp", s_axi_bresp, m_bresp);
         check("rvalid", s_axi_rvalid, m_rvalid);
         if (m_rvalid) begin
            check("rdata", s_axi_rdata, m_rdata);
            check("rresp", s_axi_rresp, m_rresp);
         end
         for (int k = 0; k < CH; k++) begin
            check($sformatf("tvalid%0d", k), m_axis_tvalid[k], mq[k].size() != 0);
            if (mq[k].size() != 0) check($sformatf("tdata%0d", k), m_axis_tdata[k*DW +: DW], mq[k][0]);
         end
      end
      tr_rnd[0] = ($urandom_range(0, 7) == 0);
      tr_rnd[1] = ($urandom_range(0, 3) == 0);
      tr_rnd[2] = ($urandom_range(0, 1) == 0);
   end

   // All driver tasks start and end on a falling edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int aw_dly,
                            input int w_dly, input int b_dly, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int cyc = 0;
      s_axi_awaddr = addr;
      s_axi_wdata  = data;
      while (!(aw_done && w_done) && cyc < 200) begin
         s_axi_awvalid = !aw_done && (cyc >= aw_dly);
         s_axi_wvalid  = !w_done && (cyc >= w_dly);
         #1;
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         @(posedge aclk);
         if (aw_hs) aw_done = 1;
         if (w_hs) w_done = 1;
         @(negedge aclk);
         cyc++;
      end
      s_axi_awvalid = 0;
      s_axi_wvalid  = 0;
      if (!(aw_done && w_done)) check("aw_w_timeout", 0, 1);
      cyc = 0;
      while (!s_axi_bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
      if (!s_axi_bvalid) begin
         check("b_timeout", 0, 1);
         resp = 2'bxx;
         return;
      end
      repeat (b_dly) @(negedge aclk);
      resp = s_axi_bresp;
      s_axi_bready = 1;
      @(negedge aclk);
      s_axi_bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit hs = 0;
      int cyc = 0;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1;
      while (!hs && cyc < 50) begin
         #1 hs = s_axi_arready;
         @(posedge aclk);
         @(negedge aclk);
         cyc++;
      end
      s_axi_arvalid = 0;
      cyc = 0;
      while (!s_axi_rvalid && cyc < 50) begin @(negedge aclk); cyc++; end
      if (!s_axi_rvalid) begin
         check("r_timeout", 0, 1);
         data = 'x;
         resp = 2'bxx;
         return;
      end
      data = s_axi_rdata;
      resp = s_axi_rresp;
      s_axi_rready = 1;
      @(negedge aclk);
      s_axi_rready = 0;
   endtask

   task automatic wait_drain(input int ch);
      int cyc = 0;
      while (m_axis_tvalid[ch] && cyc < 200) begin @(negedge aclk); cyc++; end
      check($sformatf("drain%0d", ch), m_axis_tvalid[ch], 0);
   endtask

   initial begin : main
      logic [1:0]  resp;
      logic [31:0] rd;
      int          cyc;
      aresetn = 0; chk_en = 0; rnd_mode = 0; tr_man = '0;
      s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wvalid = 0; s_axi_bready = 0;
      s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk_en = 1;
      check("rst_awready", s_axi_awready, 0);
      check("rst_arready", s_axi_arready, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      aresetn = 1;
      @(negedge aclk);

      // Single write, channel 0 drains immediately
      tr_man = 3'b001;
      axi_write(32'h0, 32'hDEADBEEF, 0, 0, 0, resp);
      check("wr_ch0_okay", resp, 2'b00);
      check("ch1_idle", m_axis_tvalid[1], 0);

      // Fill channel 1 to depth, overflow, read count, drain
      tr_man = 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
         axi_write(32'h4, $urandom, 0, 0, 0, resp);
         check($sformatf("fill1_%0d", i), resp, 2'b00);
      end
      axi_write(32'h4, 32'h1234_5678, 0, 0, 0, resp);
      check("overflow_slverr", resp, 2'b10);
      axi_read(32'h4, rd, resp);
      check("count1_full", rd, DEPTH);
      check("count1_rresp", resp, 2'b00);
      tr_man[1] = 1;
      wait_drain(1);

      // W leading AW, then AW leading W, with a slow bready
      tr_man = 3'b000;
      axi_write(32'h8, 32'hA5A5_0001, 3, 0, 5, resp);
      check("wfirst_okay", resp, 2'b00);
      axi_write(32'h8, 32'hA5A5_0002, 0, 2, 5, resp);
      check("awfirst_okay", resp, 2'b00);
      axi_read(32'h8, rd, resp);
      check("count2_two", rd, 2);
      tr_man[2] = 1;
      wait_drain(2);

      // Out-of-range channel
      axi_write(32'hC, 32'hBAD0_BAD0, 0, 0, 0, resp);
      check("oor_wr_slverr", resp, 2'b10);
      check("oor_no_tvalid", m_axis_tvalid, 0);
      axi_read(32'hC, rd, resp);
      check("oor_rd_rresp", resp, 2'b10);
      check("oor_rd_rdata", rd, 0);

      // Full FIFO: push in the same cycle as a pop is still rejected
      tr_man = 3'b000;
      for (int i = 0; i < DEPTH; i++) axi_write(32'h0, $urandom, 0, 0, 0, resp);
      s_axi_awaddr = 32'h0; s_axi_wdata = 32'hCAFE_0001;
      s_axi_awvalid = 1; s_axi_wvalid = 1;
      @(posedge aclk);
      @(negedge aclk);
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      tr_man[0] = 1;
      @(negedge aclk);
      tr_man[0] = 0;
      check("full_pop_bvalid", s_axi_bvalid, 1);
      check("full_pop_slverr", s_axi_bresp, 2'b10);
      s_axi_bready = 1;
      @(negedge aclk);
      s_axi_bready = 0;
      axi_write(32'h0, 32'hCAFE_0002, 0, 0, 0, resp);
      check("after_pop_okay", resp, 2'b00);
      axi_read(32'h0, rd, resp);
      check("after_pop_count", rd, DEPTH);
      tr_man[0] = 1;
      wait_drain(0);

      // Reset with queued words and a pending write response
      tr_man = 3'b000;
      for (int i = 0; i < 5; i++) axi_write(32'h8, $urandom, 0, 0, 0, resp);
      s_axi_awaddr = 32'h8; s_axi_wdata = 32'h5555_AAAA;
      s_axi_awvalid = 1; s_axi_wvalid = 1;
      @(posedge aclk);
      @(negedge aclk);
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      cyc = 0;
      while (!s_axi_bvalid && cyc < 10) begin @(negedge aclk); cyc++; end
      check("pre_rst_bvalid", s_axi_bvalid, 1);
      aresetn = 0;
      @(negedge aclk);
      check("rst_bvalid", s_axi_bvalid, 0);
      check("rst_tvalid_q", m_axis_tvalid, 0);
      check("rst_wready", s_axi_wready, 0);
      repeat (2) @(negedge aclk);
      aresetn = 1;
      @(negedge aclk);
      axi_read(32'h8, rd, resp);
      check("post_rst_count", rd, 0);

      // Random traffic with random sink backpressure
      rnd_mode = 1;
      for (int i = 0; i < 150; i++) begin
         logic [31:0] addr;
         addr = ($urandom & 32'hFFFF_FFF0) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0)
            axi_read(addr, rd, resp);
         else
            axi_write(addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
      end
      rnd_mode = 0;
      tr_man = '1;
      for (int k = 0; k < CH; k++) wait_drain(k);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_axis_mux_writer.md
AXI_AXIS_MUX_WRITER -- requirements
Module: axi_axis_mux_writer

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data and stream tdata width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter CHANNELS, default 2, number of output streams, legal range 1..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, words per channel FIFO, power of 2, minimum 2.
REQ-005 SHALL have port aclk, input, 1, clock; all logic is in this single domain.
REQ-006 SHALL have port aresetn, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have AXI4-Lite write ports s_axi_awaddr/awvalid/awready, s_axi_wdata/wvalid/wready and s_axi_bresp[1:0]/bvalid/bready, with standard directions and widths.
REQ-008 SHALL have AXI4-Lite read ports s_axi_araddr/arvalid/arready, s_axi_rdata/rresp[1:0]/rvalid/rready, with standard directions and widths.
REQ-009 SHALL have port m_axis_tdata, output, CHANNELS*AXI_DATA_WIDTH; channel k occupies bits [k*W +: W].
REQ-010 SHALL have ports m_axis_tvalid (output) and m_axis_tready (input), each CHANNELS wide, one bit per channel.

Function
REQ-011 Address decode SHALL be: channel index = awaddr/araddr bits [2 +: CH_BITS], CH_BITS = max(1, clog2(CHANNELS)); low two bits and upper bits are ignored.
REQ-012 AW and W SHALL be accepted independently: awready = no AW held and bvalid low; wready = no W held and bvalid low. Each accepted beat is latched.
REQ-013 With both AW and W held, the block SHALL do one push attempt in that cycle. Both holds SHALL clear and bvalid SHALL assert on the next cycle.
REQ-014 A push attempt SHALL return bresp 2'b00 and write wdata into the selected FIFO when the channel index < CHANNELS and that FIFO is not full.
REQ-015 A push attempt SHALL return bresp 2'b10 (SLVERR) and discard the data when the channel index >= CHANNELS or the FIFO is full.
REQ-016 Fullness SHALL be judged on the pre-pop count, so a push to a full FIFO is rejected even if a pop occurs in the same cycle.
REQ-017 bvalid SHALL hold until bready is sampled high. No new AW or W SHALL be accepted while bvalid is high.
REQ-018 Each channel FIFO SHALL pop when tvalid and tready are both high, and SHALL preserve order.
REQ-019 tvalid SHALL be high exactly when the count is nonzero, and tdata SHALL show the head word.
REQ-020 Latency from push to tvalid SHALL be 1 cycle on an empty FIFO; there SHALL be no write-through.
REQ-021 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Reads SHALL work as follows: arready = rvalid low; rvalid asserts 1 cycle after ar handshake and holds until rready.
REQ-023 Read data SHALL be: rdata = zero-extended count of the addressed channel (0..FIFO_DEPTH), rresp 2'b00. An out-of-range index SHALL give rdata 0 and rresp 2'b10.
REQ-024 The read and write paths SHALL be fully independent and concurrent.

Reset
REQ-025 While aresetn is low at a clock edge: all FIFO counts and pointers SHALL be 0, AW/W holds cleared, and bvalid, rvalid, tvalid, awready, wready and arready driven 0.
REQ-026 bresp, rresp and rdata SHALL reset to 0.
REQ-027 Ready outputs SHALL first assert on the cycle after aresetn is sampled high.
REQ-028 Reset mid-transaction SHALL discard held beats, pending responses and all FIFO contents, with no partial push.

Structure
REQ-029 A shared package SHALL hold the bresp/rresp encodings RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, and the clog2 helper function.
REQ-030 The per-channel FIFO SHALL be sub-module axis_sync_fifo (params WIDTH, DEPTH; ports push/data/full, tvalid/tready/tdata, count), instantiated CHANNELS times via generate.

Verification
REQ-031 Write 0xDEADBEEF to 0x0 with tready[0]=1 -> bresp OKAY; tvalid[0] high 1 cycle after push with tdata 0xDEADBEEF; channel 1 stays idle.
REQ-032 With tready[1]=0, do 16 writes to 0x4 (depth 16), then a 17th -> first 16 OKAY, 17th SLVERR; read 0x4 returns 16; raise tready -> 16 words come out in order.
REQ-033 W presented 3 cycles before AW, and AW before W -> exactly one push each, bvalid once each; hold bready low 5 cycles -> awready/wready stay low throughout.
REQ-034 CHANNELS=3, write to 0xC -> SLVERR, no tvalid change; read 0xC -> rresp SLVERR, rdata 0.
REQ-035 FIFO full with tready=1, push in same cycle as pop -> SLVERR; a push 1 cycle later -> OKAY, count 16.
REQ-036 Assert aresetn low with 5 words queued and bvalid pending -> next cycle all valid outputs 0, read of count returns 0 after release.
